parking_lot_counter: RTL and testbench
======================================

Name: parking_lot_counter

Overview:
Consumes the two debounced photo-sensor levels (a = outer beam, b = inner beam) produced by the per-sensor debounce stages. A direction FSM recognises complete car-entry and car-exit sequences and emits one-cycle event pulses. An occupancy counter tracks cars in the lot and saturates at the lot capacity. Outputs feed the parking display and gate logic.

Parameters:
MAX_CARS, 15, lot capacity; legal range 1..1023.
COUNT_W, $clog2(MAX_CARS+1), occupancy width; derived localparam, not overridable.

Ports:
clk  input  1  system clock; all logic on rising edge.
reset  input  1  asynchronous, active-high; clears all state.
a  input  1  debounced outer sensor, 1 = beam blocked; synchronous to clk; no internal synchroniser.
b  input  1  debounced inner sensor, 1 = beam blocked; synchronous to clk; no internal synchroniser.
enter  output  1  registered one-cycle pulse: completed entry.
exit  output  1  registered one-cycle pulse: completed exit.
count  output  COUNT_W  current occupancy.
full  output  1  count == MAX_CARS; combinational from the count register.
empty  output  1  count == 0; combinational from the count register.
overflow  output  1  registered one-cycle pulse: entry while full; count is held.
underflow  output  1  registered one-cycle pulse: exit while empty; count is held.

Behaviour:
- Reset values: FSM = IDLE; count = 0; enter, exit, overflow and underflow = 0. Therefore empty = 1 and full = 0.
- Reset asserted mid-sequence discards the partial sequence. There is no pulse.
- The input vector is ab = {a,b}. The FSM has 7 states: IDLE, EN1, EN2, EN3, EX1, EX2, EX3.
- IDLE: 10->EN1; 01->EX1; 00/11->IDLE (11 from IDLE is ignored).
- EN1: 10 stay; 11->EN2; 00->IDLE (car backed out); 01->IDLE (illegal).
- EN2: 11 stay; 01->EN3; 10->EN1 (reversing); 00->IDLE (illegal).
- EN3: 01 stay; 00->IDLE and the entry completes; 11->EN2 (reversing); 10->IDLE (illegal).
- EX1/EX2/EX3: mirror of EN1/EN2/EN3 with a and b swapped. EX3 plus 00 completes the exit.
- Latency:
  - On the edge that takes EN3->IDLE with ab=00, enter is registered to 1 for exactly one cycle.
  - On that same edge, count becomes count+1, or overflow pulses if count was MAX_CARS.
  - Exit behaves the same way, with count-1 or an underflow pulse if count was 0.
  - enter/exit and the count update are therefore visible in the same cycle, 1 clk after the completing input.
- enter/exit pulse even when saturated. At saturation, overflow/underflow accompany the pulse and count is unchanged.
- enter and exit are mutually exclusive by construction. No simultaneous-event arbitration is required.
- Count arithmetic is unsigned COUNT_W-bit. It never wraps; it saturates at 0 and MAX_CARS.
- An input held at a non-completing value holds state indefinitely. There is no timeout.
- Unreachable state encodings recover to IDLE on the next edge.

Decomposition:
- Package parking_pkg holds:
  - the typedef enum logic [2:0] for the FSM states (IDLE..EX3);
  - a constant function occ_width(max) returning $clog2(max+1).
- One sub-module, occupancy_counter:
  - parameter MAX_CARS;
  - inputs inc, dec;
  - outputs count, full, empty, overflow, underflow.
  - It holds the saturating counter, keeping parking_lot_counter as FSM plus pulse registers.

Test Plan:
- Reset then ab = 00,10,11,01,00 (one value per 3 cycles) -> enter=1 for one cycle 1 clk after the final 00; count 0->1; empty 1->0.
- From count=1, ab = 01,11,10,00 -> exit pulse once; count=0; empty=1.
- Partial entry with reversal: 10,11,10,00 -> no enter, no exit, count unchanged, FSM back in IDLE.
- MAX_CARS=3: 4 full entries -> count 1,2,3,3; full=1 after the third; fourth entry gives enter=1 and overflow=1 in the same cycle, count stays 3.
- From reset, one full exit sequence -> exit=1 and underflow=1 in the same cycle; count stays 0.
- Assert reset while in EN2 (ab=11), release with ab=01 then 00 -> no enter; count=0; FSM=IDLE; all pulses 0 during and after reset.

Source files
------------

// File: rtl/parking_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// parking_pkg : shared FSM state encoding and occupancy width helper
// Revision    : 1.0
// ---------------------------------------------------------------------------
package parking_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    EN1  = 3'd1,
    EN2  = 3'd2,
    EN3  = 3'd3,
    EX1  = 3'd4,
    EX2  = 3'd5,
    EX3  = 3'd6
  } state_t;

  function automatic int occ_width(input int max);
    return $clog2(max + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/occupancy_counter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// occupancy_counter : saturating car counter with overflow/underflow pulses
// Revision          : 1.0
// ---------------------------------------------------------------------------
module occupancy_counter
  import parking_pkg::*;
#(
  parameter  int MAX_CARS = 15,
  localparam int COUNT_W  = occ_width(MAX_CARS)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               inc,
  input  logic               dec,
  output logic [COUNT_W-1:0] count,
  output logic               full,
  output logic               empty,
  output logic               overflow,
  output logic               underflow
);

  localparam logic [COUNT_W-1:0] CAP  = COUNT_W'(MAX_CARS);
  localparam logic [COUNT_W-1:0] ONE  = COUNT_W'(1);
  localparam logic [COUNT_W-1:0] ZERO = '0;

  assign full  = (count == CAP);
  assign empty = (count == ZERO);

  // inc and dec never coincide, so no arbitration between them is needed
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count     <= ZERO;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      overflow  <= inc & full;
      underflow <= dec & empty;
      if (inc && !full) begin
        count <= count + ONE;
      end else if (dec && !empty) begin
        count <= count - ONE;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/parking_lot_counter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// parking_lot_counter : direction FSM on two beam sensors plus occupancy count
// Revision            : 1.0
// ---------------------------------------------------------------------------
module parking_lot_counter
  import parking_pkg::*;
#(
  parameter  int MAX_CARS = 15,
  localparam int COUNT_W  = occ_width(MAX_CARS)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               a,
  input  logic               b,
  output logic               enter,
  output logic               exit,
  output logic [COUNT_W-1:0] count,
  output logic               full,
  output logic               empty,
  output logic               overflow,
  output logic               underflow
);

  localparam logic [2:0] S_IDLE = IDLE;
  localparam logic [2:0] S_EN1  = EN1;
  localparam logic [2:0] S_EN2  = EN2;
  localparam logic [2:0] S_EN3  = EN3;
  localparam logic [2:0] S_EX1  = EX1;
  localparam logic [2:0] S_EX2  = EX2;
  localparam logic [2:0] S_EX3  = EX3;

  logic [2:0] state;
  logic [2:0] state_nx;
  logic [1:0] ab;
  logic       enter_nx;
  logic       exit_nx;

  assign ab = {a, b};

  // Exit states mirror entry states with a and b swapped
  always_comb begin
    state_nx = S_IDLE;
    enter_nx = 1'b0;
    exit_nx  = 1'b0;
    case (state)
      S_IDLE: begin
        if (ab == 2'b10)      state_nx = S_EN1;
        else if (ab == 2'b01) state_nx = S_EX1;
      end
      S_EN1: begin
        if (ab == 2'b10)      state_nx = S_EN1;
        else if (ab == 2'b11) state_nx = S_EN2;
      end
      S_EN2: begin
        if (ab == 2'b11)      state_nx = S_EN2;
        else if (ab == 2'b01) state_nx = S_EN3;
        else if (ab == 2'b10) state_nx = S_EN1;
      end
      S_EN3: begin
        if (ab == 2'b01)      state_nx = S_EN3;
        else if (ab == 2'b11) state_nx = S_EN2;
        else if (ab == 2'b00) enter_nx = 1'b1;
      end
      S_EX1: begin
        if (ab == 2'b01)      state_nx = S_EX1;
        else if (ab == 2'b11) state_nx = S_EX2;
      end
      S_EX2: begin
        if (ab == 2'b11)      state_nx = S_EX2;
        else if (ab == 2'b10) state_nx = S_EX3;
        else if (ab == 2'b01) state_nx = S_EX1;
      end
      S_EX3: begin
        if (ab == 2'b10)      state_nx = S_EX3;
        else if (ab == 2'b11) state_nx = S_EX2;
        else if (ab == 2'b00) exit_nx  = 1'b1;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
      enter <= 1'b0;
      exit  <= 1'b0;
    end else begin
      state <= state_nx;
      enter <= enter_nx;
      exit  <= exit_nx;
    end
  end

  // Counter registers on the same edge as enter/exit so both appear together
  occupancy_counter #(
    .MAX_CARS (MAX_CARS)
  ) u_occ (
    .clk       (clk),
    .reset     (reset),
    .inc       (enter_nx),
    .dec       (exit_nx),
    .count     (count),
    .full      (full),
    .empty     (empty),
    .overflow  (overflow),
    .underflow (underflow)
  );

endmodule
`default_nettype wire

// File: tb/tb_parking_lot_counter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_parking_lot_counter : directed vectors for default and small-capacity lots
// Revision               : 1.0
// ---------------------------------------------------------------------------
module tb_parking_lot_counter;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       a = 1'b0, b = 1'b0;
  logic       a3 = 1'b0, b3 = 1'b0;

  logic       enter, exit, full, empty, overflow, underflow;
  logic [3:0] count;
  logic       enter3, exit3, full3, empty3, overflow3, underflow3;
  logic [1:0] count3;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  parking_lot_counter dut (
    .clk(clk), .reset(reset), .a(a), .b(b),
    .enter(enter), .exit(exit), .count(count), .full(full), .empty(empty),
    .overflow(overflow), .underflow(underflow)
  );

  parking_lot_counter #(.MAX_CARS(3)) dut3 (
    .clk(clk), .reset(reset), .a(a3), .b(b3),
    .enter(enter3), .exit(exit3), .count(count3), .full(full3), .empty(empty3),
    .overflow(overflow3), .underflow(underflow3)
  );

  // Packed observation: {enter, exit, full, empty, overflow, underflow, count[3:0]}
  typedef struct {
    logic [1:0] ab;
    int         hold;
    logic [9:0] exp;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic [1:0] ab, input int hold,
                              input logic en, input logic ex, input logic [3:0] cnt,
                              input logic ovf, input logic unf);
    vec_t v;
    v.ab   = ab;
    v.hold = hold;
    v.exp  = {en, ex, (cnt == 4'd15), (cnt == 4'd0), ovf, unf, cnt};
    return v;
  endfunction

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b required %b", nm, act, exp);
    end
  endtask

  function automatic logic [9:0] obs();
    return {enter, exit, full, empty, overflow, underflow, count};
  endfunction

  function automatic logic [7:0] obs3();
    return {enter3, exit3, full3, empty3, overflow3, underflow3, count3};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One complete entry on the capacity-3 lot, checked on the completing edge
  task automatic entry3(input string nm, input logic [1:0] cnt, input logic ovf);
    logic [3:0] seq;
    logic [7:0] exp;
    for (int i = 0; i < 4; i++) begin
      seq = {(i == 0), (i == 1 || i == 2), (i == 3), 1'b0};
      {a3, b3} = (i == 0) ? 2'b10 : (i == 1) ? 2'b11 : (i == 2) ? 2'b01 : 2'b00;
      tick();
    end
    exp = {1'b1, 1'b0, (cnt == 2'd3), (cnt == 2'd0), ovf, 1'b0, cnt};
    chk(nm, 16'(obs3()), 16'(exp));
    tick();
    exp[7] = 1'b0;
    exp[3] = 1'b0;
    chk({nm, "_after"}, 16'(obs3()), 16'(exp));
  endtask

  initial begin
    logic [9:0] e;

    // Default lot: full entry, exit, partial entry, ignored 11, underflow, reversal
    vecs.push_back(mk(2'b00, 3, 0, 0, 0, 0, 0));
    vecs.push_back(mk(2'b10, 3, 0, 0, 0, 0, 0));
    vecs.push_back(mk(2'b11, 3, 0, 0, 0, 0, 0));
    vecs.push_back(mk(2'b01, 3, 0, 0, 0, 0, 0));
    vecs.push_back(mk(2'b00, 3, 1, 0, 1, 0, 0));
    vecs.push_back(mk(2'b01, 3, 0, 0, 1, 0, 0));
    vecs.push_back(mk(2'b11, 3, 0, 0, 1, 0, 0));
    vecs.push_back(mk(2'b10, 3, 0, 0, 1, 0, 0));
    vecs.push_back(mk(2'b00, 3, 0, 1, 0, 0, 0));
    vecs.push_back(mk(2'b10, 2, 0, 0, 0, 0, 0));
    vecs.push_back(mk(2'b11, 2, 0, 0, 0, 0, 0));
    vecs.push_back(mk(2'b10, 2, 0, 0, 0, 0, 0));
    vecs.push_back(mk(2'b00, 2, 0, 0, 0, 0, 0));
    vecs.push_back(mk(2'b10, 1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(2'b11, 1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(2'b01, 1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(2'b00, 1, 1, 0, 1, 0, 0));
    vecs.push_back(mk(2'b11, 2, 0, 0, 1, 0, 0));
    vecs.push_back(mk(2'b00, 1, 0, 0, 1, 0, 0));
    vecs.push_back(mk(2'b01, 1, 0, 0, 1, 0, 0));
    vecs.push_back(mk(2'b11, 1, 0, 0, 1, 0, 0));
    vecs.push_back(mk(2'b10, 1, 0, 0, 1, 0, 0));
    vecs.push_back(mk(2'b00, 1, 0, 1, 0, 0, 0));
    vecs.push_back(mk(2'b01, 1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(2'b11, 1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(2'b10, 1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(2'b00, 1, 0, 1, 0, 0, 1));
    vecs.push_back(mk(2'b10, 1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(2'b11, 1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(2'b01, 1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(2'b11, 1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(2'b01, 1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(2'b00, 1, 1, 0, 1, 0, 0));
    vecs.push_back(mk(2'b10, 1, 0, 0, 1, 0, 0));
    vecs.push_back(mk(2'b01, 1, 0, 0, 1, 0, 0));
    vecs.push_back(mk(2'b00, 2, 0, 0, 1, 0, 0));

    reset = 1'b1;
    tick();
    chk("reset_dut", 16'(obs()), 16'(mk(2'b00, 1, 0, 0, 0, 0, 0).exp));
    chk("reset_dut3", 16'(obs3()), 16'(8'b0001_0000));
    @(negedge clk);
    reset = 1'b0;
    #1;

    foreach (vecs[i]) begin
      {a, b} = vecs[i].ab;
      tick();
      chk($sformatf("vec%0d", i), 16'(obs()), 16'(vecs[i].exp));
      e = vecs[i].exp;
      e[9] = 1'b0; e[8] = 1'b0; e[5] = 1'b0; e[4] = 1'b0;
      for (int h = 1; h < vecs[i].hold; h++) begin
        tick();
        chk($sformatf("vec%0d_hold%0d", i, h), 16'(obs()), 16'(e));
      end
    end

    // Capacity-3 lot saturates and flags the fourth entry
    entry3("sat_entry1", 2'd1, 1'b0);
    entry3("sat_entry2", 2'd2, 1'b0);
    entry3("sat_entry3", 2'd3, 1'b0);
    entry3("sat_entry4", 2'd3, 1'b1);

    // Reset while in EN2 discards the partial entry (default lot holds count 1)
    {a, b} = 2'b10;
    tick();
    {a, b} = 2'b11;
    tick();
    reset = 1'b1;
    #1;
    chk("mid_reset_async", 16'(obs()), 16'(mk(2'b00, 1, 0, 0, 0, 0, 0).exp));
    tick();
    tick();
    chk("mid_reset_held", 16'(obs()), 16'(mk(2'b00, 1, 0, 0, 0, 0, 0).exp));
    chk("mid_reset_dut3", 16'(obs3()), 16'(8'b0001_0000));
    @(negedge clk);
    reset = 1'b0;
    {a, b} = 2'b01;
    tick();
    chk("post_reset_01", 16'(obs()), 16'(mk(2'b00, 1, 0, 0, 0, 0, 0).exp));
    {a, b} = 2'b00;
    tick();
    chk("post_reset_00", 16'(obs()), 16'(mk(2'b00, 1, 0, 0, 0, 0, 0).exp));
    tick();
    chk("post_reset_idle", 16'(obs()), 16'(mk(2'b00, 1, 0, 0, 0, 0, 0).exp));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
